// File: rtl/slave_port_2k.sv
// slave_port_2k: target end of the serial bus. Accepts a serial address (and
// serial write data) on one bit line, backs a 2**ADDR_W x DATA_W local memory
// and returns read data LSB first on a separate serial line.
//
// Ports:
//   CLK       system clock, rising edge
//   RST       asynchronous active-high reset
//   B_UTIL    initiator holds high for the whole transaction
//   B_RW      1 = write, 0 = read; sampled in IDLE only
//   B_BUS_IN  serial address / write data, LSB first
//   B_ACK     one-cycle acknowledge of a new transaction
//   B_DONE    one-cycle completion pulse
//   B_BUS_OUT serial read data, LSB first
module slave_port_2k #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic B_UTIL,
  input  logic B_RW,
  input  logic B_BUS_IN,
  output logic B_ACK,
  output logic B_DONE,
  output logic B_BUS_OUT
);

  localparam int unsigned MaxW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CntW = $clog2(MaxW);
  localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_W - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StAddr,
    StWdata,
    StMemrd,
    StRdata,
    StDone,
    StRel
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rw_q, rw_d;
  logic                ack_q, ack_d;
  logic                done_q, done_d;
  logic                bus_out_q, bus_out_d;
  logic                mem_we;

  logic [DATA_W-1:0]   mem [Depth];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    mem_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (B_UTIL) begin
          rw_d    = B_RW;
          state_d = StAck;
        end
      end
      StAck: begin
        cnt_d   = '0;
        state_d = StAddr;
      end
      StAddr: begin
        // LSB first: after ADDR_W shifts bit 0 has reached the bottom.
        addr_d = {B_BUS_IN, addr_q[ADDR_W-1:1]};
        if (cnt_q == AddrLast) begin
          cnt_d   = '0;
          state_d = rw_q ? StWdata : StMemrd;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWdata: begin
        data_d = {B_BUS_IN, data_q[DATA_W-1:1]};
        if (cnt_q == DataLast) begin
          // Word written includes the bit captured on this same edge.
          mem_we  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StMemrd: begin
        data_d  = mem[addr_q];
        cnt_d   = '0;
        state_d = StRdata;
      end
      StRdata: begin
        data_d = data_q >> 1;
        if (cnt_q == DataLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StRel;
      StRel: begin
        // A held B_UTIL must drop for a cycle before a new transaction.
        if (!B_UTIL) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Initiator abandoning the transaction: no write, no completion pulse.
    if (!B_UTIL && (state_q inside {StAck, StAddr, StWdata, StMemrd, StRdata})) begin
      state_d = StIdle;
      cnt_d   = '0;
      mem_we  = 1'b0;
    end
  end

  // Outputs are decoded from next state so they are registered yet aligned
  // with the state they belong to.
  always_comb begin
    ack_d     = (state_d == StAck);
    done_d    = (state_d == StDone);
    bus_out_d = (state_d == StRdata) && data_d[0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      bus_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      bus_out_q <= bus_out_d;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[addr_q] <= data_d;
  end

  assign B_ACK     = ack_q;
  assign B_DONE    = done_q;
  assign B_BUS_OUT = bus_out_q;

endmodule

// File: tb/tb_slave_port_2k.sv
// Directed bench for slave_port_2k: write/read, boundary addresses, abort,
// held B_UTIL, asynchronous reset mid-read and a short random run.
module tb_slave_port_2k;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic B_UTIL = 1'b0;
  logic B_RW = 1'b0;
  logic B_BUS_IN = 1'b0;
  logic B_ACK, B_DONE, B_BUS_OUT;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0, done_seen = 0;
  int exp_ack = 0, exp_done = 0;
  logic rd_win = 1'b0;

  logic [7:0] model [0:2047];
  int written [$];

  slave_port_2k #(.ADDR_W(11), .DATA_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .B_UTIL   (B_UTIL),
    .B_RW     (B_RW),
    .B_BUS_IN (B_BUS_IN),
    .B_ACK    (B_ACK),
    .B_DONE   (B_DONE),
    .B_BUS_OUT(B_BUS_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: pulse counting and B_BUS_OUT outside the read window.
  always @(negedge CLK) begin
    if (!RST) begin
      if (B_ACK) ack_seen++;
      if (B_DONE) done_seen++;
      if (!rd_win) check("bus_out_idle", {31'd0, B_BUS_OUT}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Edge 0: IDLE sees B_UTIL. Returns after edge 1 (state ADDR).
  task automatic start_txn(input logic rw);
    B_UTIL = 1'b1;
    B_RW   = rw;
    tick();
    exp_ack++;
    check("ack_cycle1", {31'd0, B_ACK}, 32'd1);
    check("done_cycle1", {31'd0, B_DONE}, 32'd0);
    B_RW = ~rw;  // ignored after IDLE
    tick();
    check("ack_cycle2", {31'd0, B_ACK}, 32'd0);
  endtask

  task automatic send_addr(input logic [10:0] addr);
    for (int i = 0; i < 11; i++) begin
      B_BUS_IN = addr[i];
      tick();
      check("addr_no_ack", {31'd0, B_ACK}, 32'd0);
      check("addr_no_done", {31'd0, B_DONE}, 32'd0);
    end
  endtask

  task automatic do_write(input logic [10:0] addr, input logic [7:0] data, input logic hold);
    start_txn(1'b1);
    send_addr(addr);
    for (int j = 0; j < 8; j++) begin
      B_BUS_IN = data[j];
      tick();
      check("wr_done", {31'd0, B_DONE}, (j == 7) ? 32'd1 : 32'd0);
    end
    exp_done++;
    model[addr] = data;
    written.push_back(int'(addr));
    B_BUS_IN = 1'b0;
    tick();
    check("wr_done_fall", {31'd0, B_DONE}, 32'd0);
    if (!hold) begin
      B_UTIL = 1'b0;
      tick();
    end
  endtask

  task automatic do_read(input logic [10:0] addr, output logic [7:0] d);
    start_txn(1'b0);
    send_addr(addr);
    check("memrd_bus_out", {31'd0, B_BUS_OUT}, 32'd0);
    rd_win = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      d[k] = B_BUS_OUT;
      check("rd_no_done", {31'd0, B_DONE}, 32'd0);
    end
    tick();
    rd_win = 1'b0;
    exp_done++;
    check("rd_done", {31'd0, B_DONE}, 32'd1);
    check("rd_done_bus_out", {31'd0, B_BUS_OUT}, 32'd0);
    tick();
    check("rd_done_fall", {31'd0, B_DONE}, 32'd0);
    B_UTIL = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] pat;
    logic [10:0] ra;
    logic [7:0] rdat;

    // Reset state
    #2;
    check("rst_ack", {31'd0, B_ACK}, 32'd0);
    check("rst_done", {31'd0, B_DONE}, 32'd0);
    check("rst_bus_out", {31'd0, B_BUS_OUT}, 32'd0);
    tick();
    tick();
    RST = 1'b0;
    tick();

    // Write 0x5A to 0x123, read back with bit-level check
    do_write(11'h123, 8'h5A, 1'b0);
    do_read(11'h123, rd);
    check("rd_123", {24'd0, rd}, 32'h5A);

    // Boundary addresses
    do_write(11'h7FF, 8'hFF, 1'b0);
    do_write(11'h000, 8'h01, 1'b0);
    do_read(11'h7FF, rd);
    check("rd_7ff", {24'd0, rd}, 32'hFF);
    do_read(11'h000, rd);
    check("rd_000", {24'd0, rd}, 32'h01);

    // Abort a write after 5 data bits
    do_write(11'h010, 8'h33, 1'b0);
    start_txn(1'b1);
    send_addr(11'h010);
    pat = 8'hAA;
    for (int j = 0; j < 5; j++) begin
      B_BUS_IN = pat[j];
      tick();
    end
    B_UTIL = 1'b0;
    tick();
    for (int j = 0; j < 3; j++) begin
      check("abort_no_done", {31'd0, B_DONE}, 32'd0);
      check("abort_no_ack", {31'd0, B_ACK}, 32'd0);
      tick();
    end
    do_read(11'h010, rd);
    check("rd_010_after_abort", {24'd0, rd}, 32'h33);

    // Held B_UTIL must not start a second transaction
    do_write(11'h055, 8'hC3, 1'b1);
    for (int j = 0; j < 10; j++) begin
      tick();
      check("hold_no_ack", {31'd0, B_ACK}, 32'd0);
    end
    B_UTIL = 1'b0;
    tick();
    B_UTIL = 1'b1;
    B_RW   = 1'b0;
    tick();
    exp_ack++;
    check("reraise_ack", {31'd0, B_ACK}, 32'd1);
    B_UTIL = 1'b0;
    tick();
    tick();

    // Asynchronous reset during RDATA bit 3
    start_txn(1'b0);
    send_addr(11'h123);
    rd_win = 1'b1;
    rd = 8'h00;
    for (int k = 0; k < 4; k++) begin
      tick();
      rd[k] = B_BUS_OUT;
    end
    check("rd_nibble_before_rst", {28'd0, rd[3:0]}, 32'hA);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_bus_out", {31'd0, B_BUS_OUT}, 32'd0);
    check("async_rst_ack", {31'd0, B_ACK}, 32'd0);
    check("async_rst_done", {31'd0, B_DONE}, 32'd0);
    rd_win = 1'b0;
    B_UTIL = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    do_read(11'h123, rd);
    check("rd_123_after_rst", {24'd0, rd}, 32'h5A);

    // Random transactions against the model
    for (int t = 0; t < 20; t++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
        ra   = 11'($urandom_range(0, 2047));
        rdat = 8'($urandom_range(0, 255));
        do_write(ra, rdat, 1'b0);
      end else begin
        ra = 11'(written[$urandom_range(0, written.size() - 1)]);
        do_read(ra, rd);
        check("rand_rd", {24'd0, rd}, {24'd0, model[ra]});
      end
    end

    tick();
    check("ack_pulse_count", ack_seen, exp_ack);
    check("done_pulse_count", done_seen, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slave_port_2k.md
Name: slave_port_2k

Overview:
- Bus-side serial responder: the target end of the serial bus protocol driven by the initiator port (B_UTIL / B_ACK / B_RW / B_DONE / serial data).
- Accepts a serial address, plus serial data for writes, over one bit line.
- Backs a 2K x 8 local memory; returns read data on a separate serial line.
- Sits on the bus behind the arbiter/decoder.

Parameters:
- ADDR_W, 11, serial address bits; memory depth = 2**ADDR_W.
- DATA_W, 8, data word width / serial data bits.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- B_UTIL  input  1  initiator holds high for the entire transaction.
- B_RW  input  1  1 = write, 0 = read; sampled only with B_UTIL in IDLE.
- B_BUS_IN  input  1  serial address/write data from initiator, LSB first.
- B_ACK  output  1  one-cycle acknowledge of a new transaction.
- B_DONE  output  1  one-cycle completion pulse.
- B_BUS_OUT  output  1  serial read data to initiator, LSB first.

Behaviour:
- Reset: async, active-high. While RST = 1: state = IDLE; B_ACK, B_DONE and B_BUS_OUT = 0; bit counter, address register and data shift register = 0. Memory contents are not reset.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, ACK, ADDR, WDATA, MEMRD, RDATA, DONE, REL.
- IDLE: if B_UTIL = 1, latch rw = B_RW and go to ACK.
- ACK:
  - B_ACK = 1 for exactly this cycle.
  - Clear counter; go to ADDR.
  - The initiator presents address bit 0 in the cycle after B_ACK is high.
- ADDR:
  - Each cycle shift B_BUS_IN into addr[cnt], cnt = 0..ADDR_W-1.
  - After bit ADDR_W-1: go to WDATA if rw = 1, else MEMRD.
- WDATA:
  - Each cycle capture B_BUS_IN into wdata[cnt], cnt = 0..DATA_W-1.
  - After bit DATA_W-1: write mem[addr] = assembled word (the final bit is included, captured on the same edge); go to DONE.
- MEMRD: one cycle of synchronous memory read into the shift register; go to RDATA.
- RDATA:
  - Drive B_BUS_OUT = rdata[cnt] for cnt = 0..DATA_W-1, one bit per cycle.
  - After DATA_W cycles: go to DONE, with B_BUS_OUT = 0.
- DONE: B_DONE = 1 for exactly one cycle; go to REL.
- REL:
  - Wait for B_UTIL = 0, then go to IDLE.
  - Prevents a held B_UTIL from starting a second transaction; a new transaction needs B_UTIL low for at least one cycle.
- Abort: B_UTIL = 0 in ACK, ADDR, WDATA, MEMRD or RDATA returns to IDLE next cycle.
  - No memory write occurs; B_DONE is not asserted; B_BUS_OUT = 0.
- B_BUS_OUT is 0 in every state other than RDATA.
- Latency, counting the IDLE edge that sees B_UTIL as cycle 0:
  - B_ACK high in cycle 1.
  - Address bits sampled at cycles 2..12.
  - Write: data sampled at cycles 13..20; B_DONE high in cycle 21.
  - Read: MEMRD in cycle 13; read bits driven in cycles 14..21; B_DONE high in cycle 22.
- Address is exactly ADDR_W bits, so there is no out-of-range case; 0x7FF is the last location. Counters saturate at their terminal count and never wrap mid-field.
- Reset mid-transaction: immediate return to IDLE with outputs 0. A write interrupted before the WDATA terminal edge leaves memory unchanged.
- B_RW and B_BUS_IN are ignored outside the states that sample them.

Test Plan:
- Write 0x5A to addr 0x123, then read 0x123 -> B_ACK at cycle 1; B_DONE at cycle 21 (write) and 22 (read); B_BUS_OUT serial read bits 0,1,0,1,1,0,1,0 (LSB first) in cycles 14..21.
- Write 0xFF to 0x7FF and 0x01 to 0x000, then read both -> 0xFF and 0x01 returned; no aliasing between boundary addresses.
- Drop B_UTIL after 5 data bits of a write of 0xAA to 0x010 (0x010 previously held 0x33) -> IDLE next cycle; no B_DONE; a later read of 0x010 returns 0x33.
- Hold B_UTIL high after B_DONE for 10 cycles -> no second B_ACK. Drop B_UTIL for 1 cycle, raise it again -> B_ACK one cycle later.
- Assert RST asynchronously (mid-cycle) during RDATA bit 3 -> B_BUS_OUT, B_ACK and B_DONE are 0 immediately. After release, a new read of the same address returns the full, correct byte.
- Pulse width check over 20 random transactions -> B_ACK and B_DONE are each high exactly one cycle per transaction; B_BUS_OUT is never 1 outside RDATA.
